rrp_otf_conv: RTL

- Digit-serial, most-significant-digit-first (MSDF) on-the-fly converter for the radix-r signed-digit datapath.
- Consumes the redundant signed-digit stream produced by the online multiplier/adder pipeline, one digit per accepted beat.
- Emits the equivalent conventional two's-complement integer after the last digit, with no carry-propagate adder: it uses Q/QM concatenation registers.
- Sits at the output end of the online datapath, feeding conventional-binary consumers.

---
 rtl/rrp_pkg.sv | 30 +++
 rtl/rrp_otf_step.sv | 48 ++++
 rtl/rrp_otf_conv.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rrp_pkg.sv
// ----------------------------------------------------------------------------
// rrp_pkg
//   Shared definitions for the radix-r signed-digit online datapath:
//   digit-width derivation helpers, the digit-legality check and the
//   handshake state encoding used by the on-the-fly converter.
// ----------------------------------------------------------------------------
package rrp_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Bits contributed to the conventional result per digit (RADIX is 2^K).
   function automatic int bits_per_digit(input int radix);
      return $clog2(radix);
   endfunction

   // Two's-complement width needed to carry one signed digit.
   function automatic int digit_width(input int radix);
      return $clog2(radix) + 1;
   endfunction

   // Legal digits are -(radix-1)..(radix-1). -radix is encodable in the
   // digit width but lies outside the redundant digit set.
   function automatic logic digit_legal(input int digit, input int radix);
      return (digit > -radix) && (digit < radix);
   endfunction

endpackage

// File: rtl/rrp_otf_step.sv
// ----------------------------------------------------------------------------
// rrp_otf_step
//   Combinational single-digit on-the-fly conversion step. Given the current
//   Q (value so far) and QM (value so far minus one ulp) registers and one
//   signed digit, produces the updated Q and QM without any carry chain.
//
//   Ports:
//     digit   - signed digit, two's complement, D bits
//     q_in    - current Q register
//     qm_in   - current QM register
//     q_next  - Q after appending digit
//     qm_next - QM after appending digit
// ----------------------------------------------------------------------------
module rrp_otf_step
   import rrp_pkg::*;
#(
   parameter  int RADIX = 4,
   parameter  int OW    = 9,
   localparam int K     = bits_per_digit(RADIX),
   localparam int D     = digit_width(RADIX)
) (
   input  logic [D-1:0]  digit,
   input  logic [OW-1:0] q_in,
   input  logic [OW-1:0] qm_in,
   output logic [OW-1:0] q_next,
   output logic [OW-1:0] qm_next
);

   logic [D-1:0] digit_m1;
   logic         is_neg;
   logic         is_pos;

   // NOTE: every variable assigned in an always_comb block receives a value on
   // every path, so no latch can be inferred.
   always_comb begin
      is_neg   = digit[D-1];
      is_pos   = !digit[D-1] && (digit != '0);
      digit_m1 = digit - D'(1);
      // Because r = 2^K, (r+q) has the same low K bits as q and (r-1+q) the
      // same low K bits as q-1, so each branch appends the same digit bits
      // and only the choice of source register differs.
      q_next  = is_neg ? {qm_in[OW-K-1:0], digit[K-1:0]}
                       : {q_in[OW-K-1:0],  digit[K-1:0]};
      qm_next = is_pos ? {q_in[OW-K-1:0],  digit_m1[K-1:0]}
                       : {qm_in[OW-K-1:0], digit_m1[K-1:0]};
   end

endmodule

// File: rtl/rrp_otf_conv.sv
// ----------------------------------------------------------------------------
// rrp_otf_conv
//   MSDF on-the-fly converter: accepts WIDTH signed radix-RADIX digits, most
//   significant first, and presents the equivalent two's-complement integer
//   on q_out one cycle after the last digit is accepted. The result is held
//   until downstream takes it with q_ready.
//
//   Ports:
//     clock     - rising-edge clock
//     reset     - asynchronous, active-high reset
//     din       - signed digit (D bits, two's complement)
//     din_valid - din carries a digit
//     din_ready - converter accepts a digit this cycle
//     q_out     - registered two's-complement result (OW bits)
//     q_valid   - q_out holds a complete result
//     q_ready   - downstream consumes q_out
//     digit_err - sticky: a -RADIX digit was accepted in the current word
// ----------------------------------------------------------------------------
module rrp_otf_conv
   import rrp_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int RADIX = 4,
   localparam int D     = digit_width(RADIX),
   localparam int K     = bits_per_digit(RADIX),
   localparam int OW    = K * WIDTH + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [D-1:0]  din,
   input  logic          din_valid,
   output logic          din_ready,
   output logic [OW-1:0] q_out,
   output logic          q_valid,
   input  logic          q_ready,
   output logic          digit_err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t        state;
   state_t        state_nxt;
   logic          rdy_reg;
   logic [CW-1:0] cnt;
   logic [OW-1:0] q_reg;
   logic [OW-1:0] qm_reg;
   logic [OW-1:0] q_step;
   logic [OW-1:0] qm_step;
   logic          accept;
   logic          last_digit;
   logic          handshake;
   logic          illegal;

   assign accept     = din_valid && din_ready;
   assign last_digit = (cnt == CW'(WIDTH - 1));
   assign handshake  = q_valid && q_ready;
   assign illegal    = !digit_legal(int'($signed(din)), RADIX);

   rrp_otf_step #(
      .RADIX (RADIX),
      .OW    (OW)
   ) u_step (
      .digit   (din),
      .q_in    (q_reg),
      .qm_in   (qm_reg),
      .q_next  (q_step),
      .qm_next (qm_step)
   );

   // State register. din_ready is registered from the next state so that it
   // stays low while reset is asserted and rises on the first clock after.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= COLLECT;
         rdy_reg <= 1'b0;
      end else begin
         state   <= state_nxt;
         rdy_reg <= (state_nxt == COLLECT);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         COLLECT: if (accept && last_digit) state_nxt = HOLD;
         HOLD:    if (handshake)            state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   // Outputs derived directly from state registers.
   always_comb begin
      din_ready = rdy_reg;
      q_valid   = (state == HOLD);
   end

   // Datapath: counter, Q/QM concatenation registers and the result register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         q_reg  <= '0;
         qm_reg <= '1;
         q_out  <= '0;
      end else if (accept) begin
         if (last_digit) begin
            q_out  <= q_step;
            cnt    <= '0;
            q_reg  <= '0;
            qm_reg <= '1;
         end else begin
            q_reg  <= q_step;
            qm_reg <= qm_step;
            cnt    <= cnt + CW'(1);
         end
      end
   end

   // Sticky error flag: set by any -RADIX digit, cleared when the word is
   // taken. Accepts happen only in COLLECT and handshakes only in HOLD.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digit_err <= 1'b0;
      end else if (accept && illegal) begin
         digit_err <= 1'b1;
      end else if (handshake) begin
         digit_err <= 1'b0;
      end
   end

endmodule
